// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl
// ------------
// Program-counter and flow-control stage of the 5-stage pipeline. It picks
// the next fetch address from one of four sources:
//   - sequential (pc_IF + 1)
//   - PC-relative branch/jump-immediate (pc_ID_EX + 1 + imm_ID_EX)
//   - register jump (reg_target_ID_EX)
//   - rti return (epc)
// It also raises the IF/ID and ID/EX flushes and runs a single-level
// interrupt controller that keeps one saved return address (epc).
//
// Ports
//   clk                in   system clock; all state changes on the rising edge
//   rst                in   asynchronous, active-high reset
//   stall_IM_ID        in   hazard stall; pc_IF holds unless a redirect wins
//   flow_change_ID_EX  in   take branch/jump/rti this cycle
//   jmp_reg_ID_EX      in   EX instruction is a jump-register
//   rti_ID_EX          in   EX instruction is an rti
//   pc_ID_EX           in   address of the instruction in EX
//   imm_ID_EX          in   sign-extended branch/jump offset
//   reg_target_ID_EX   in   forwarded register-jump target
//   ctrl_instr_IF_ID   in   ID holds a branch/jump/rti
//   int_req            in   level-sensitive interrupt request
//   pc_IF              out  current fetch address (registered)
//   pc_plus1_IF        out  pc_IF + 1, wraps at 2^PC_W
//   flush_IF_ID        out  kill the instruction being fetched
//   flush_ID_EX        out  kill the instruction in ID
//   int_ack            out  high in the cycle interrupt entry is taken
//   in_isr             out  high while in service; this is the FSM state bit
//   epc                out  saved return address
//
// Control semantics: there is no valid/ready handshake at this stage.
// stall_IM_ID is a hold request. flow_change_ID_EX is a one-cycle command
// that is always accepted and takes priority over the stall. int_req is a
// level request that is accepted only in a cycle where entry is eligible.
// int_ack reports that acceptance in the same cycle.

module pc_flow_ctrl #(
  parameter int          PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = 16'h0000,
  parameter logic [PC_W-1:0] INT_VEC   = 16'h0010
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_IM_ID,
  input  logic            flow_change_ID_EX,
  input  logic            jmp_reg_ID_EX,
  input  logic            rti_ID_EX,
  input  logic [PC_W-1:0] pc_ID_EX,
  input  logic [PC_W-1:0] imm_ID_EX,
  input  logic [PC_W-1:0] reg_target_ID_EX,
  input  logic            ctrl_instr_IF_ID,
  input  logic            int_req,
  output logic [PC_W-1:0] pc_IF,
  output logic [PC_W-1:0] pc_plus1_IF,
  output logic            flush_IF_ID,
  output logic            flush_ID_EX,
  output logic            int_ack,
  output logic            in_isr,
  output logic [PC_W-1:0] epc
);

  typedef enum logic {
    RUN = 1'b0,
    ISR = 1'b1
  } state_t;

  state_t          state;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] branch_target;
  logic            ent;

  // Sums are taken at PC_W bits, so any carry out is dropped and addresses
  // wrap modulo 2^PC_W.
  assign pc_plus1_IF   = pc_IF + {{(PC_W-1){1'b0}}, 1'b1};
  assign branch_target = pc_ID_EX + {{(PC_W-1){1'b0}}, 1'b1} + imm_ID_EX;

  always_comb begin
    target = branch_target;
    if (rti_ID_EX) begin
      target = epc;
    end else if (jmp_reg_ID_EX) begin
      target = reg_target_ID_EX;
    end
  end

  // Entry waits while a control instruction sits in ID or a redirect is
  // resolving in EX. Saving pc_IF in those cycles could capture a
  // wrong-path address. A stall also defers entry, because pc_IF is not
  // advancing and the fetch slot is not free.
  assign ent = int_req & (state == RUN) & ~flow_change_ID_EX &
               ~ctrl_instr_IF_ID & ~stall_IM_ID;

  // The decision outputs are combinational in the deciding cycle and are
  // held low while reset is asserted.
  assign flush_IF_ID = ~rst & (flow_change_ID_EX | ent);
  assign flush_ID_EX = ~rst & flow_change_ID_EX;
  assign int_ack     = ~rst & ent;
  assign in_isr      = (state == ISR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_IF <= RESET_VEC;
      epc   <= '0;
      state <= RUN;
    end else if (flow_change_ID_EX) begin
      pc_IF <= target;
      // A taken rti always leaves the ISR. In RUN it still jumps to epc,
      // and the state stays RUN.
      if (rti_ID_EX) begin
        state <= RUN;
      end
    end else if (ent) begin
      epc   <= pc_IF;
      pc_IF <= INT_VEC;
      state <= ISR;
    end else if (!stall_IM_ID) begin
      pc_IF <= pc_plus1_IF;
    end
  end

endmodule

// File: doc/pc_flow_ctrl.md
# pc_flow_ctrl

Program-counter and flow-control stage for the 5-stage pipeline. It consumes the EX-stage `flow_change_ID_EX` decision from the branch evaluator and selects the next fetch address: sequential, PC-relative branch/jump-immediate, register jump, or `rti` return. It generates IF/ID and ID/EX flushes, and handles a single-level external interrupt with a saved return address (EPC). It sits between EX-stage branch resolution and the instruction memory address port.

## Interface
- `PC_W`, 16, width of all addresses
- `RESET_VEC`, 16'h0000, PC after reset
- `INT_VEC`, 16'h0010, PC loaded on interrupt entry

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall_IM_ID`  in  1  hazard stall; hold PC
- `flow_change_ID_EX`  in  1  take branch/jump/rti now (from branch evaluator)
- `jmp_reg_ID_EX`  in  1  EX instruction is jump-register
- `rti_ID_EX`  in  1  EX instruction is rti
- `pc_ID_EX`  in  PC_W  address of instruction in EX
- `imm_ID_EX`  in  PC_W  sign-extended branch/jump offset
- `reg_target_ID_EX`  in  PC_W  register-jump target (forwarded)
- `ctrl_instr_IF_ID`  in  1  ID holds a branch/jump/rti
- `int_req`  in  1  level interrupt request
- `pc_IF`  out  PC_W  current fetch address (registered)
- `pc_plus1_IF`  out  PC_W  pc_IF + 1, wraps
- `flush_IF_ID`  out  1  kill instruction being fetched
- `flush_ID_EX`  out  1  kill instruction in ID
- `int_ack`  out  1  one-cycle pulse on interrupt entry
- `in_isr`  out  1  high while in service (state ISR)
- `epc`  out  PC_W  saved return address

## Operation
- State machine `RUN`, `ISR`; `in_isr` = (state == `ISR`).
- Redirect target when `flow_change_ID_EX`:
  - if `rti_ID_EX`, then `epc`;
  - else if `jmp_reg_ID_EX`, then `reg_target_ID_EX`;
  - else `pc_ID_EX + 1 + imm_ID_EX`, modulo 2^PC_W, with carry discarded.
- Interrupt entry condition `ent` = `int_req` & state==`RUN` & ~`flow_change_ID_EX` & ~`ctrl_instr_IF_ID` & ~`stall_IM_ID`.
- Next-PC priority, highest first:
  1. `flow_change_ID_EX`: pc_IF <= target. This wins over stall.
  2. `ent`: epc <= pc_IF; pc_IF <= INT_VEC; state -> `ISR`.
  3. `stall_IM_ID`: pc_IF holds.
  4. Otherwise pc_IF <= pc_plus1_IF; FFFF wraps to 0000.
- `rti` taken (`flow_change_ID_EX` & `rti_ID_EX`): state -> `RUN`. In `RUN`, rti still jumps to `epc` and the state is unchanged.
- `int_req` while in `ISR` is ignored; there is no nesting. A request still high after rti re-enters at the first eligible cycle.
- Flushes:
  - `flush_IF_ID` = `flow_change_ID_EX` | `ent`.
  - `flush_ID_EX` = `flow_change_ID_EX`.
  - Both are combinational in the deciding cycle.
- `epc` changes only on `ent`.

## Timing
- Reset (async, immediate): pc_IF=RESET_VEC, pc_plus1_IF=RESET_VEC+1, epc=0, state `RUN`, in_isr=0, int_ack=0. Flush outputs follow inputs; with rst high, both are forced 0.
- Redirect latency: `flow_change_ID_EX` high in cycle N gives pc_IF = target in cycle N+1. Fetched and ID instructions of cycle N are flushed; the branch penalty is 2 cycles.
- Interrupt latency: `ent` in cycle N gives `int_ack`=1 in cycle N only (combinational = `ent`), pc_IF=INT_VEC and in_isr=1 in cycle N+1.
- Stall and flow change in the same cycle: the redirect occurs and the flush is asserted.
- `int_req` with `ctrl_instr_IF_ID` or `flow_change_ID_EX` high: entry defers. This guarantees epc is never a wrong-path address.
- Reset mid-ISR: state returns to `RUN` and epc clears; a pending `int_req` is eligible the first cycle after reset release.
- `int_req` sampled only at the edge; glitches between edges have no effect.

## Test plan
- Reset/sequential: assert rst mid-cycle, release → pc_IF=0000 immediately; after 3 edges pc_IF=0003. Preload so pc_IF=FFFF → next 0000.
- Branch: pc_ID_EX=0010, imm=FFFC (−4), flow_change=1 for one cycle → flush_IF_ID=flush_ID_EX=1 that cycle, next pc_IF=000D. Same with stall_IM_ID=1 → identical result.
- Jump-register / not-taken: jmp_reg=1, reg_target=1234, flow_change=1 → pc_IF=1234. flow_change=0 with br/jmp inputs high → no flush, PC increments.
- Interrupt entry/return: pc_IF=0040, int_req=1, no blockers → int_ack pulse, flush_IF_ID=1, flush_ID_EX=0, next pc_IF=0010, epc=0040, in_isr=1. Later rti_ID_EX+flow_change → pc_IF=0040, in_isr=0.
- Blocking: int_req=1 with ctrl_instr_IF_ID=1 for 2 cycles → no ack, PC advances; ack on the third cycle with epc = that cycle's pc_IF. int_req held in ISR → no second ack until after rti.
- Reset in ISR: enter ISR, assert rst → in_isr=0, epc=0000, pc_IF=0000 before the next edge.
